// File: rtl/cpu_pkg.sv
// Shared pipeline-control constants: forward-select codes and hazard FSM state encoding.
package cpu_pkg;

    localparam int unsigned FWD_SEL_W = 2;
    localparam int unsigned RET_CNT_W = 3;

    localparam logic [FWD_SEL_W-1:0] FWD_REG   = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDSTALL = 2'd1,
        RETWAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-field bundle seen by the hazard controller; master = pipeline side, slave = controller.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [REG_W-1:0] idex_rs1;
    logic [REG_W-1:0] idex_rs2;
    logic [REG_W-1:0] idex_dest;
    logic             idex_regwrite;
    logic             idex_memread;
    logic             idex_call;
    logic             idex_ret;
    logic [REG_W-1:0] exmem_dest;
    logic             exmem_regwrite;
    logic [REG_W-1:0] memwb_dest;
    logic             memwb_regwrite;
    logic             stall_pc;
    logic             stall_ifid;
    logic             bubble_idex;
    logic             flush_ifid;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, idex_rs1, idex_rs2, idex_dest,
               idex_regwrite, idex_memread, idex_call, idex_ret,
               exmem_dest, exmem_regwrite, memwb_dest, memwb_regwrite,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, idex_rs1, idex_rs2, idex_dest,
               idex_regwrite, idex_memread, idex_call, idex_ret,
               exmem_dest, exmem_regwrite, memwb_dest, memwb_regwrite,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_sel1, fwd_sel2
    );
endinterface

// File: rtl/hazard_fwd_mux_sel.sv
// Per-operand compare against EX/MEM and MEM/WB writers; EX/MEM wins, register 0 never matches.
module hazard_fwd_mux_sel
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0]     rs,
    input  logic [REG_W-1:0]     exmem_dest,
    input  logic                 exmem_regwrite,
    input  logic [REG_W-1:0]     memwb_dest,
    input  logic                 memwb_regwrite,
    output logic [FWD_SEL_W-1:0] sel_c
);

    always_comb begin
        sel_c = FWD_REG;
        if (exmem_regwrite && (exmem_dest != '0) && (exmem_dest == rs)) begin
            sel_c = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_dest != '0) && (memwb_dest == rs)) begin
            sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: stall/bubble/flush decode and operand forward selects.
// HAZARD_FWD_EN defined enables forwarding with load-use stalls; undefined stalls on any RAW hazard.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned RET_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [RET_CNT_W-1:0] RET_INIT = RET_CNT_W'(RET_LAT - 1);

    hz_state_t            state_q;
    logic [RET_CNT_W-1:0] ret_cnt_q;
    logic [REG_W-1:0]     cmp_rs1_c;
    logic [REG_W-1:0]     cmp_rs2_c;
    logic [FWD_SEL_W-1:0] sel1_c;
    logic [FWD_SEL_W-1:0] sel2_c;
    logic                 data_stall_c;

    // Forwarding compares the EX operands; without it the same compare checks ID sources for RAW.
`ifdef HAZARD_FWD_EN
    assign cmp_rs1_c = hz.idex_rs1;
    assign cmp_rs2_c = hz.idex_rs2;
`else
    assign cmp_rs1_c = hz.id_rs1;
    assign cmp_rs2_c = hz.id_rs2;
`endif

    hazard_fwd_mux_sel #(.REG_W(REG_W)) u_sel1 (
        .rs             (cmp_rs1_c),
        .exmem_dest     (hz.exmem_dest),
        .exmem_regwrite (hz.exmem_regwrite),
        .memwb_dest     (hz.memwb_dest),
        .memwb_regwrite (hz.memwb_regwrite),
        .sel_c          (sel1_c)
    );

    hazard_fwd_mux_sel #(.REG_W(REG_W)) u_sel2 (
        .rs             (cmp_rs2_c),
        .exmem_dest     (hz.exmem_dest),
        .exmem_regwrite (hz.exmem_regwrite),
        .memwb_dest     (hz.memwb_dest),
        .memwb_regwrite (hz.memwb_regwrite),
        .sel_c          (sel2_c)
    );

`ifdef HAZARD_FWD_EN
    logic ld_hit1_c;
    logic ld_hit2_c;

    assign ld_hit1_c    = hz.id_use1 && (hz.id_rs1 == hz.idex_dest);
    assign ld_hit2_c    = hz.id_use2 && (hz.id_rs2 == hz.idex_dest);
    assign data_stall_c = hz.idex_memread && (hz.idex_dest != '0) && (ld_hit1_c || ld_hit2_c);
    assign hz.fwd_sel1  = rst ? FWD_REG : sel1_c;
    assign hz.fwd_sel2  = rst ? FWD_REG : sel2_c;
`else
    logic ex_hit1_c;
    logic ex_hit2_c;

    assign ex_hit1_c    = hz.idex_regwrite && (hz.idex_dest != '0) && (hz.idex_dest == hz.id_rs1);
    assign ex_hit2_c    = hz.idex_regwrite && (hz.idex_dest != '0) && (hz.idex_dest == hz.id_rs2);
    assign data_stall_c = (hz.id_use1 && (ex_hit1_c || (sel1_c != FWD_REG))) ||
                          (hz.id_use2 && (ex_hit2_c || (sel2_c != FWD_REG)));
    assign hz.fwd_sel1  = FWD_REG;
    assign hz.fwd_sel2  = FWD_REG;
`endif

    // State register; ret leaves RETWAIT once the decremented count would reach zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ret_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz.idex_ret) begin
                        state_q   <= RETWAIT;
                        ret_cnt_q <= RET_INIT;
                    end
`ifdef HAZARD_FWD_EN
                    else if (!hz.idex_call && data_stall_c) begin
                        state_q <= LDSTALL;
                    end
`endif
                end
                LDSTALL: state_q <= IDLE;
                RETWAIT: begin
                    if (ret_cnt_q <= RET_CNT_W'(1)) begin
                        state_q   <= IDLE;
                        ret_cnt_q <= '0;
                    end else begin
                        ret_cnt_q <= ret_cnt_q - RET_CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ret_cnt_q <= '0;
                end
            endcase
        end
    end

    // Mealy decode: reset > ret > call > data stall; LDSTALL holds the bubble and stays quiet.
    always_comb begin
        hz.stall_pc    = 1'b0;
        hz.stall_ifid  = 1'b0;
        hz.bubble_idex = 1'b0;
        hz.flush_ifid  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (hz.idex_ret) begin
                        hz.stall_pc   = 1'b1;
                        hz.flush_ifid = 1'b1;
                    end else if (hz.idex_call) begin
                        hz.flush_ifid = 1'b1;
                    end else if (data_stall_c) begin
                        hz.stall_pc    = 1'b1;
                        hz.stall_ifid  = 1'b1;
                        hz.bubble_idex = 1'b1;
                    end
                end
                RETWAIT: begin
                    hz.stall_pc   = 1'b1;
                    hz.flush_ifid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FWD_EN when it is defined.
module tb_hazard_ctrl;

    localparam int unsigned REG_W = 5;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    hazard_ctrl_if #(.REG_W(REG_W)) hz  ();
    hazard_ctrl_if #(.REG_W(REG_W)) hz4 ();

    hazard_ctrl #(.REG_W(REG_W), .RET_LAT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    hazard_ctrl #(.REG_W(REG_W), .RET_LAT(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .hz  (hz4)
    );

    // {stall_pc, stall_ifid, bubble_idex, flush_ifid}
    wire [3:0] ctl  = {hz.stall_pc,  hz.stall_ifid,  hz.bubble_idex,  hz.flush_ifid};
    wire [3:0] ctl4 = {hz4.stall_pc, hz4.stall_ifid, hz4.bubble_idex, hz4.flush_ifid};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs1 = '0;  hz.id_rs2 = '0;  hz.id_use1 = 1'b0;  hz.id_use2 = 1'b0;
        hz.idex_rs1 = '0; hz.idex_rs2 = '0; hz.idex_dest = '0;
        hz.idex_regwrite = 1'b0; hz.idex_memread = 1'b0; hz.idex_call = 1'b0; hz.idex_ret = 1'b0;
        hz.exmem_dest = '0; hz.exmem_regwrite = 1'b0; hz.memwb_dest = '0; hz.memwb_regwrite = 1'b0;
        hz4.id_rs1 = '0; hz4.id_rs2 = '0; hz4.id_use1 = 1'b0; hz4.id_use2 = 1'b0;
        hz4.idex_rs1 = '0; hz4.idex_rs2 = '0; hz4.idex_dest = '0;
        hz4.idex_regwrite = 1'b0; hz4.idex_memread = 1'b0; hz4.idex_call = 1'b0; hz4.idex_ret = 1'b0;
        hz4.exmem_dest = '0; hz4.exmem_regwrite = 1'b0; hz4.memwb_dest = '0; hz4.memwb_regwrite = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        hz.idex_ret = 1'b1;
        hz4.idex_ret = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (ctl !== 4'b0000) begin $display("FAIL reset_hold: ctl=%b expected %b", ctl, 4'b0000); fails++; end
            checks++; if (ctl4 !== 4'b0000) begin $display("FAIL reset_hold4: ctl=%b expected %b", ctl4, 4'b0000); fails++; end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL reset_release: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        checks++; if (ctl4 !== 4'b0000) begin $display("FAIL reset_release4: ctl=%b expected %b", ctl4, 4'b0000); fails++; end
        checks++; if ({hz.fwd_sel1, hz.fwd_sel2} !== 4'b0000) begin $display("FAIL reset_fwd: fwd=%b expected %b", {hz.fwd_sel1, hz.fwd_sel2}, 4'b0000); fails++; end
        tick();
    endtask

    task automatic test_forward();
        logic [1:0] e;
        clear_inputs();
        hz.exmem_regwrite = 1'b1; hz.exmem_dest = REG_W'(5);
        hz.memwb_regwrite = 1'b1; hz.memwb_dest = REG_W'(5);
        hz.idex_rs1 = REG_W'(5);  hz.idex_rs2 = REG_W'(9);
        @(negedge clk);
        e = FWD ? 2'b01 : 2'b00;
        checks++; if (hz.fwd_sel1 !== e) begin $display("FAIL fwd_both_match: sel1=%b expected %b", hz.fwd_sel1, e); fails++; end
        checks++; if (hz.fwd_sel2 !== 2'b00) begin $display("FAIL fwd_no_match: sel2=%b expected %b", hz.fwd_sel2, 2'b00); fails++; end
        checks++; if (ctl !== 4'b0000) begin $display("FAIL fwd_no_stall: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
        hz.exmem_regwrite = 1'b0;
        @(negedge clk);
        e = FWD ? 2'b10 : 2'b00;
        checks++; if (hz.fwd_sel1 !== e) begin $display("FAIL fwd_memwb: sel1=%b expected %b", hz.fwd_sel1, e); fails++; end
        tick();
        hz.idex_rs1 = '0;
        @(negedge clk);
        checks++; if (hz.fwd_sel1 !== 2'b00) begin $display("FAIL fwd_rs_zero: sel1=%b expected %b", hz.fwd_sel1, 2'b00); fails++; end
        tick();
        hz.exmem_regwrite = 1'b1; hz.exmem_dest = REG_W'(6);
        hz.idex_rs1 = REG_W'(6);  hz.idex_rs2 = REG_W'(5);
        @(negedge clk);
        e = FWD ? 2'b01 : 2'b00;
        checks++; if (hz.fwd_sel1 !== e) begin $display("FAIL fwd_split1: sel1=%b expected %b", hz.fwd_sel1, e); fails++; end
        e = FWD ? 2'b10 : 2'b00;
        checks++; if (hz.fwd_sel2 !== e) begin $display("FAIL fwd_split2: sel2=%b expected %b", hz.fwd_sel2, e); fails++; end
        tick();
        hz.exmem_dest = '0; hz.memwb_dest = '0; hz.idex_rs1 = '0; hz.idex_rs2 = '0;
        @(negedge clk);
        checks++; if ({hz.fwd_sel1, hz.fwd_sel2} !== 4'b0000) begin $display("FAIL fwd_reg0: fwd=%b expected %b", {hz.fwd_sel1, hz.fwd_sel2}, 4'b0000); fails++; end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [3:0] e;
        clear_inputs();
        hz.idex_memread = 1'b1; hz.idex_regwrite = 1'b1; hz.idex_dest = REG_W'(7);
        hz.id_rs2 = REG_W'(7);  hz.id_use2 = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 4'b1110) begin $display("FAIL ldu_first: ctl=%b expected %b", ctl, 4'b1110); fails++; end
        tick();
        @(negedge clk);
        e = FWD ? 4'b0000 : 4'b1110;
        checks++; if (ctl !== e) begin $display("FAIL ldu_second: ctl=%b expected %b", ctl, e); fails++; end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL ldu_after: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
        hz.idex_memread = 1'b1; hz.idex_regwrite = 1'b1; hz.idex_dest = REG_W'(7);
        hz.id_rs2 = REG_W'(7);
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL ldu_unused_src: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
        clear_inputs();
        hz.idex_memread = 1'b1; hz.idex_regwrite = 1'b1; hz.id_use1 = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL ldu_reg0: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
        clear_inputs();
    endtask

    task automatic test_ret();
        for (int r = 0; r < 2; r++) begin
            clear_inputs();
            hz.idex_ret = 1'b1;
            if (r == 1) begin
                hz.idex_memread = 1'b1; hz.idex_regwrite = 1'b1; hz.idex_dest = REG_W'(7);
                hz.id_rs1 = REG_W'(7);  hz.id_use1 = 1'b1;
            end
            @(negedge clk);
            checks++; if (ctl !== 4'b1001) begin $display("FAIL ret_entry%0d: ctl=%b expected %b", r, ctl, 4'b1001); fails++; end
            tick();
            clear_inputs();
            @(negedge clk);
            checks++; if (ctl !== 4'b1001) begin $display("FAIL ret_wait%0d: ctl=%b expected %b", r, ctl, 4'b1001); fails++; end
            tick();
            @(negedge clk);
            checks++; if (ctl !== 4'b0000) begin $display("FAIL ret_done%0d: ctl=%b expected %b", r, ctl, 4'b0000); fails++; end
            tick();
        end
    endtask

    task automatic test_ret_lat4();
        int n;
        n = 0;
        clear_inputs();
        hz4.idex_ret = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (ctl4 == 4'b1001) n++;
            tick();
            hz4.idex_ret = 1'b0;
        end
        checks++; if (n !== 4) begin $display("FAIL ret_lat4_cycles: got %0d expected %0d", n, 4); fails++; end
    endtask

    task automatic test_call();
        clear_inputs();
        hz.idex_call = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 4'b0001) begin $display("FAIL call_flush: ctl=%b expected %b", ctl, 4'b0001); fails++; end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL call_after: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
        hz.idex_call = 1'b1;
        hz.idex_memread = 1'b1; hz.idex_regwrite = 1'b1; hz.idex_dest = REG_W'(7);
        hz.id_rs2 = REG_W'(7);  hz.id_use2 = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 4'b0001) begin $display("FAIL call_over_ldu: ctl=%b expected %b", ctl, 4'b0001); fails++; end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL call_ldu_after: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
    endtask

    task automatic test_reset_mid_ret();
        clear_inputs();
        hz.idex_ret = 1'b1;
        hz4.idex_ret = 1'b1;
        @(negedge clk);
        checks++; if (ctl4 !== 4'b1001) begin $display("FAIL rstret_entry4: ctl=%b expected %b", ctl4, 4'b1001); fails++; end
        tick();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ctl4 !== 4'b0000) begin $display("FAIL rstret_during4: ctl=%b expected %b", ctl4, 4'b0000); fails++; end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ctl4 !== 4'b0000) begin $display("FAIL rstret_after4: ctl=%b expected %b", ctl4, 4'b0000); fails++; end
        checks++; if (ctl !== 4'b0000) begin $display("FAIL rstret_after: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        tick();
    endtask

    task automatic test_raw_stall();
        int         n;
        logic [3:0] ec;
        logic [1:0] ef;
        n = 0;
        clear_inputs();
        hz.id_rs1 = REG_W'(3); hz.id_use1 = 1'b1; hz.idex_rs1 = REG_W'(3);
        hz.idex_dest = REG_W'(3); hz.exmem_dest = REG_W'(3); hz.memwb_dest = REG_W'(3);
        for (int s = 0; s < 3; s++) begin
            hz.idex_regwrite  = (s == 0);
            hz.exmem_regwrite = (s == 1);
            hz.memwb_regwrite = (s == 2);
            @(negedge clk);
            if (ctl == 4'b1110) n++;
            ec = FWD ? 4'b0000 : 4'b1110;
            ef = !FWD ? 2'b00 : (s == 1) ? 2'b01 : (s == 2) ? 2'b10 : 2'b00;
            checks++; if (ctl !== ec) begin $display("FAIL raw_stage%0d: ctl=%b expected %b", s, ctl, ec); fails++; end
            checks++; if (hz.fwd_sel1 !== ef) begin $display("FAIL raw_fwd%0d: sel1=%b expected %b", s, hz.fwd_sel1, ef); fails++; end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 4'b0000) begin $display("FAIL raw_clear: ctl=%b expected %b", ctl, 4'b0000); fails++; end
        checks++; if (n !== (FWD ? 0 : 3)) begin $display("FAIL raw_stall_cycles: got %0d expected %0d", n, FWD ? 0 : 3); fails++; end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_ret();
        test_ret_lat4();
        test_call();
        test_reset_mid_ret();
        test_raw_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
